// File: rtl/hrmf_reorder.sv
// Ping-pong 8x8 transpose buffer: digit-reversed HRMF frames in, natural-order frames out.
// Define HRMF_REORDER_SOF_EN to add the OUT_SOF/OUT_EOF frame markers.
module hrmf_reorder #(
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    input  logic [DW-1:0] D4,
    input  logic [DW-1:0] D5,
    input  logic [DW-1:0] D6,
    input  logic [DW-1:0] D7,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] Q0,
    output logic [DW-1:0] Q1,
    output logic [DW-1:0] Q2,
    output logic [DW-1:0] Q3,
    output logic [DW-1:0] Q4,
    output logic [DW-1:0] Q5,
    output logic [DW-1:0] Q6,
    output logic [DW-1:0] Q7
`ifdef HRMF_REORDER_SOF_EN
    ,
    output logic          OUT_SOF,
    output logic          OUT_EOF
`endif
);

    logic [DW-1:0] d_lane [8];
    logic [DW-1:0] q_lane [8];
    // Address {bank, row, col}: writes fill a column per beat, reads sweep a row.
    logic [DW-1:0] mem_q  [128];

    logic       wb_q, wb_d, rb_q, rb_d;
    logic [2:0] wc_q, wc_d, rc_q, rc_d;
    logic [1:0] full_q, full_d;
    logic       wr_en, rd_en;

    assign d_lane[0] = D0;
    assign d_lane[1] = D1;
    assign d_lane[2] = D2;
    assign d_lane[3] = D3;
    assign d_lane[4] = D4;
    assign d_lane[5] = D5;
    assign d_lane[6] = D6;
    assign d_lane[7] = D7;

    assign IN_READY  = !full_q[wb_q];
    assign OUT_VALID = full_q[rb_q];
    assign wr_en     = IN_VALID && IN_READY;
    assign rd_en     = OUT_VALID && OUT_READY;

    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wb_d   = wb_q;
        wc_d   = wc_q;
        rb_d   = rb_q;
        rc_d   = rc_q;
        full_d = full_q;
        if (wr_en) begin
            wc_d = wc_q + 3'd1;
            if (wc_q == 3'd7) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end
        // Final write and final read always hit different banks, so both updates survive.
        if (rd_en) begin
            rc_d = rc_q + 3'd1;
            if (rc_q == 3'd7) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wb_q   <= 1'b0;
            wc_q   <= 3'd0;
            rb_q   <= 1'b0;
            rc_q   <= 3'd0;
            full_q <= 2'b00;
        end else begin
            wb_q   <= wb_d;
            wc_q   <= wc_d;
            rb_q   <= rb_d;
            rc_q   <= rc_d;
            full_q <= full_d;
        end
    end

    // NOTE: bank storage has no reset; FULL flags alone decide whether its contents are visible.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int l = 0; l < 8; l++) begin
                mem_q[{wb_q, 3'(l), wc_q}] <= d_lane[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 8; l++) begin
            q_lane[l] = OUT_VALID ? mem_q[{rb_q, rc_q, 3'(l)}] : '0;
        end
    end

    assign Q0 = q_lane[0];
    assign Q1 = q_lane[1];
    assign Q2 = q_lane[2];
    assign Q3 = q_lane[3];
    assign Q4 = q_lane[4];
    assign Q5 = q_lane[5];
    assign Q6 = q_lane[6];
    assign Q7 = q_lane[7];

`ifdef HRMF_REORDER_SOF_EN
    assign OUT_SOF = OUT_VALID && (rc_q == 3'd0);
    assign OUT_EOF = OUT_VALID && (rc_q == 3'd7);
`endif

endmodule

// File: tb/tb_hrmf_reorder.sv
// Directed bench for hrmf_reorder: frame transpose, back-to-back flow, backpressure, stalls, mid-frame reset.
module tb_hrmf_reorder;

    logic        CLK;
    logic        RSTn;
    logic        IN_VALID;
    logic        IN_READY;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [63:0] d [8];
    logic [63:0] q [8];
`ifdef HRMF_REORDER_SOF_EN
    logic        OUT_SOF;
    logic        OUT_EOF;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Stream position of the bench itself: next beat to send and next beat expected.
    int in_f, in_b, out_f, out_b;
    int tag_base;
    int stalls, bubbles, accepted;
    bit out_started;

    hrmf_reorder #(.DW(64)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .D0       (d[0]),
        .D1       (d[1]),
        .D2       (d[2]),
        .D3       (d[3]),
        .D4       (d[4]),
        .D5       (d[5]),
        .D6       (d[6]),
        .D7       (d[7]),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Q0       (q[0]),
        .Q1       (q[1]),
        .Q2       (q[2]),
        .Q3       (q[3]),
        .Q4       (q[4]),
        .Q5       (q[5]),
        .Q6       (q[6]),
        .Q7       (q[7])
`ifdef HRMF_REORDER_SOF_EN
        ,
        .OUT_SOF  (OUT_SOF),
        .OUT_EOF  (OUT_EOF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample k of frame f: frame tag in the real half, k in the imaginary half.
    function automatic logic [63:0] smp(input int f, input int k);
        return {32'(f + tag_base), 32'(k)};
    endfunction

    function automatic logic [511:0] exp_beat(input int f, input int b);
        logic [511:0] r;
        for (int l = 0; l < 8; l++) r[l*64 +: 64] = smp(f, b*8 + l);
        return r;
    endfunction

    function automatic logic [511:0] q_cat();
        logic [511:0] r;
        for (int l = 0; l < 8; l++) r[l*64 +: 64] = q[l];
        return r;
    endfunction

    task automatic reset_counters();
        in_f = 0; in_b = 0; out_f = 0; out_b = 0;
        stalls = 0; bubbles = 0; accepted = 0;
        out_started = 1'b0;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic step(input int pin, input int pout, input int nf);
        logic iv, orr;
        iv  = (in_f < nf) && ($urandom_range(1, 100) <= pin);
        orr = ($urandom_range(1, 100) <= pout);
        IN_VALID  = iv;
        OUT_READY = orr;
        for (int l = 0; l < 8; l++) d[l] = iv ? smp(in_f, l*8 + in_b) : 64'h0;
        if (OUT_VALID) begin
            out_started = 1'b1;
            check($sformatf("q_f%0d_b%0d", out_f, out_b), q_cat(), exp_beat(out_f, out_b));
`ifdef HRMF_REORDER_SOF_EN
            check("sof", OUT_SOF, out_b == 0);
            check("eof", OUT_EOF, out_b == 7);
`endif
            if (orr) begin
                if (out_b == 7) begin out_b = 0; out_f++; end
                else out_b++;
            end
        end else if (out_started && out_f < nf) begin
            bubbles++;
        end
        if (iv && !IN_READY) stalls++;
        if (iv && IN_READY) begin
            accepted++;
            if (in_b == 7) begin in_b = 0; in_f++; end
            else in_b++;
        end
        @(posedge CLK); #1;
    endtask

    task automatic run(input int pin, input int pout, input int nf, input int budget);
        int cyc = 0;
        while (out_f < nf && cyc < budget) begin
            step(pin, pout, nf);
            cyc++;
        end
        IN_VALID = 1'b0;
        check("frames_out", out_f, nf);
        check("drained_valid", OUT_VALID, 1'b0);
    endtask

    initial begin
        RSTn      = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        tag_base  = 0;
        for (int l = 0; l < 8; l++) d[l] = 64'h0;
        reset_counters();

        // Reset values
        #1;
        check("rst_in_ready", IN_READY, 1'b1);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_q", q_cat(), 512'h0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Single frame, Dl = k: output appears the cycle after beat 7
        tag_base = 0;
        for (int b = 0; b < 8; b++) begin
            check("single_pre_valid", OUT_VALID, 1'b0);
            step(100, 100, 1);
        end
        check("single_latency_valid", OUT_VALID, 1'b1);
        check("single_beat0", q_cat(), exp_beat(0, 0));
        run(100, 100, 1, 20);

        // Back-to-back frames: no input stall, no output bubble
        reset_counters();
        tag_base = 100;
        run(100, 100, 4, 100);
        check("b2b_stalls", stalls, 0);
        check("b2b_bubbles", bubbles, 0);

        // Backpressure: both banks fill, then release
        reset_counters();
        tag_base = 200;
        for (int c = 0; c < 20; c++) step(100, 0, 3);
        check("bp_accepted", accepted, 16);
        check("bp_in_ready", IN_READY, 1'b0);
        check("bp_out_valid", OUT_VALID, 1'b1);
        check("bp_q_hold", q_cat(), exp_beat(0, 0));
        run(100, 100, 3, 100);

        // Random IN_VALID / OUT_READY stalls
        reset_counters();
        tag_base = 1000;
        run(50, 50, 100, 6000);
        check("rand_in_frames", in_f, 100);

        // Reset mid-frame 1 with frame 0 full
        reset_counters();
        tag_base = 300;
        for (int c = 0; c < 8; c++) step(100, 0, 2);
        for (int c = 0; c < 5; c++) step(100, 0, 2);
        check("pre_rst_out_valid", OUT_VALID, 1'b1);
        IN_VALID = 1'b0;
        RSTn = 1'b0;
        #1;
        check("mid_rst_out_valid", OUT_VALID, 1'b0);
        check("mid_rst_q", q_cat(), 512'h0);
        check("mid_rst_in_ready", IN_READY, 1'b1);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        reset_counters();
        tag_base = 400;
        run(100, 100, 1, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hrmf_reorder.md
# hrmf_reorder

Frame reorder buffer on the output side of the HRMF datapath. It accepts 64-point frames as 8 beats of 8 complex lanes, in the radix-8 digit-reversed order that HRMF produces. It returns each frame in natural order, again 8 beats of 8 lanes. Storage is a flop-based ping-pong pair of 64-entry banks, so one frame can be filled while the previous one drains, and both sides use valid/ready handshakes.

## Interface
- DW, 64, complex sample width: {real[DW-1:DW/2], imag[DW/2-1:0]}, two's complement; data passes through unmodified.
- CLK  in  1  clock, all state updates on posedge.
- RSTn  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  input beat accepted when IN_VALID && IN_READY.
- D0..D7  in  DW each  input lanes of one beat.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  output beat consumed when OUT_VALID && OUT_READY.
- Q0..Q7  out  DW each  output lanes of one beat.
- OUT_SOF, OUT_EOF  out  1 each  present only with HRMF_REORDER_SOF_EN (see Configuration).

## Operation
- Index map, frame sample index k in 0..63:
  - Input beat b (0..7), lane Dl holds X[l*8+b].
  - Output beat b, lane Ql presents X[b*8+l].
  - The block is therefore an 8x8 transpose per frame.
- Two banks, BANK0 and BANK1, each 64 x DW. Bank storage is not reset.
- Per-bank FULL flag.
- Write side: bank pointer WB and beat counter WC (3 bits).
  - IN_READY = !FULL[WB].
  - On accept: entry l*8+WC of bank WB <= Dl, for all l; WC <= WC+1.
  - On accept with WC==7: FULL[WB] <= 1, WB toggles, WC wraps to 0.
- Read side: bank pointer RB and beat counter RC (3 bits).
  - OUT_VALID = FULL[RB].
  - Ql = bank RB entry RC*8+l when OUT_VALID, otherwise 0.
  - On consume: RC <= RC+1.
  - On consume with RC==7: FULL[RB] <= 0, RB toggles, RC wraps to 0.
- Per-bank state is EMPTY (FULL=0, not WB or being written) -> FILLING (WB==bank, WC>0) -> FULL -> DRAINING (RB==bank, RC>0) -> EMPTY.
- Frames leave in arrival order. RB always trails WB by at most one bank.
- Both banks FULL: IN_READY=0, and input is stalled until the last beat of RB is consumed.
- Both banks EMPTY: OUT_VALID=0.
- Same cycle, final write to one bank and final read of the other: both flag updates take effect, and neither is lost.
- Same bank cannot complete a write and a read in the same cycle, because writing requires FULL=0 and reading requires FULL=1.
- A write beat to a bank while IN_VALID=0 is impossible; the write enable is the handshake only.
- OUT_READY held low: output beat and lanes stay stable until consumed.
- IN_VALID held low mid-frame: WC holds and the partial frame is kept.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, Q0..Q7=0, OUT_SOF=OUT_EOF=0, WB=RB=0, WC=RC=0, FULL=00.
- Reset asserted mid-frame discards all partial and full frames. Outputs take their reset values asynchronously.
- Latency: OUT_VALID rises the cycle after the 8th input beat of a frame is accepted.
  - First output beat can be consumed in that cycle.
  - Minimum frame latency is 8 cycles from the first input beat to the first output beat.
- Q lanes are a combinational mux from registered storage and registered RC/RB. There is no combinational path from D* or IN_VALID to any output.
- IN_READY depends only on registered state. There is no combinational path from OUT_READY to IN_READY.
- Sustained throughput with IN_VALID=OUT_READY=1 is 1 beat per cycle on each side, 8 cycles per frame, with no bubbles.

## Configuration
- HRMF_REORDER_SOF_EN defined:
  - OUT_SOF and OUT_EOF ports exist.
  - OUT_SOF = OUT_VALID && RC==0.
  - OUT_EOF = OUT_VALID && RC==7.
- HRMF_REORDER_SOF_EN undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Single frame: send Dl = k = l*8+b over 8 beats with OUT_READY=1 -> OUT_VALID rises the cycle after beat 7; output beat b gives Ql = b*8+l, i.e. beat 0 = 0..7 and beat 7 = 56..63; OUT_VALID=0 after.
- Back-to-back: 4 frames with frame tag in the real half, continuous valid/ready -> IN_READY stays 1, outputs in tag order, no idle cycle between frames after the first.
- Backpressure: OUT_READY=0 while 3 frames are offered -> IN_READY drops after beat 15 (16th accepted beat); Q holds beat 0 of frame 0; raising OUT_READY releases frames in order with data intact.
- Random stall: random IN_VALID and OUT_READY (50%), 100 frames -> output matches the transpose model; no beat dropped or duplicated.
- Reset mid-frame: assert RSTn=0 after beat 4 of frame 1 while frame 0 is full -> immediately OUT_VALID=0, Q=0, IN_READY=1; next full frame reorders correctly from bank 0.
- With HRMF_REORDER_SOF_EN: OUT_SOF is high only on output beat 0 and OUT_EOF only on beat 7 of each frame, including under OUT_READY stalls.
